// File: rtl/btb_fetch_target.sv
// btb_fetch_target: direct-mapped branch target buffer for the Fetch stage.
// Looks up pcF every cycle, combines the hit with the direction predictor to
// form the speculative next PC, and is trained from the Memory stage with
// resolved branch/jump targets. Hit and target are pipelined into Decode.
module btb_fetch_target #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        pred_takeF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchM,
    input  logic        jumpM,
    input  logic        actual_takeM,
    input  logic [31:0] pcM,
    input  logic [31:0] targetM,
    output logic        hitF,
    output logic [31:0] targetF,
    output logic        redirectF,
    output logic [31:0] next_pcF,
    output logic        hitD,
    output logic [31:0] pred_targetD
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // Per-entry state: valid/jumpbit are resettable flag vectors, tag/target
    // are plain storage that is only meaningful behind a set valid bit.
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  jump_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_m;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_m;
    logic                  jumpbit_f;
    logic                  wr_en;

    // PC bits outside the index/tag fields play no part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[1:0], pcF[31:TAG_HI+1], pcM[1:0], pcM[31:TAG_HI+1]};

    assign idx_f = pcF[TAG_LO-1:2];
    assign idx_m = pcM[TAG_LO-1:2];
    assign tag_f = pcF[TAG_HI:TAG_LO];
    assign tag_m = pcM[TAG_HI:TAG_LO];

    // Jumps always install; branches install only when resolved taken, so a
    // not-taken outcome leaves any existing entry for the predictor to handle.
    assign wr_en = jumpM | (branchM & actual_takeM);

    // Zero-latency lookup and next-PC selection; reads see pre-edge contents,
    // so a same-cycle write to the same index is not bypassed.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        hitF      = 1'b0;
        jumpbit_f = 1'b0;
        targetF   = target_q[idx_f];
        if (valid_q[idx_f] && (tag_q[idx_f] == tag_f)) begin
            hitF      = 1'b1;
            jumpbit_f = jump_q[idx_f];
        end
        redirectF = hitF & (pred_takeF | jumpbit_f);
        next_pcF  = redirectF ? targetF : pcF + 32'd4;
    end

    // Valid and jumpbit flags: reset wins over a simultaneous update, and a
    // simultaneous jump/branch is recorded as a jump.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= '0;
            jump_q  <= '0;
        end else if (wr_en) begin
            valid_q[idx_m] <= 1'b1;
            jump_q[idx_m]  <= jumpM;
        end
    end

    // Tag and target storage, written alongside the flags.
    always_ff @(posedge clk) begin
        // NOTE: the tag/target arrays are deliberately not reset; a cleared valid bit makes them unreachable.
        if (wr_en) begin
            tag_q[idx_m]    <= tag_m;
            target_q[idx_m] <= targetM;
        end
    end

    // Decode-stage copy of the prediction; flush beats stall.
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            hitD         <= 1'b0;
            pred_targetD <= 32'd0;
        end else if (!stallD) begin
            hitD         <= redirectF;
            pred_targetD <= targetF;
        end
    end

endmodule

// File: tb/tb_btb_fetch_target.sv
// tb_btb_fetch_target: directed self-checking bench for btb_fetch_target.
// Inputs change 1 ns after the rising edge; combinational outputs are sampled
// 1 ns after that, registered outputs right after the edge that loads them.
module tb_btb_fetch_target;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        pred_takeF;
    logic        stallD;
    logic        flushD;
    logic        branchM;
    logic        jumpM;
    logic        actual_takeM;
    logic [31:0] pcM;
    logic [31:0] targetM;
    logic        hitF;
    logic [31:0] targetF;
    logic        redirectF;
    logic [31:0] next_pcF;
    logic        hitD;
    logic [31:0] pred_targetD;

    int n_checks = 0;
    int n_pass   = 0;

    btb_fetch_target #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .pred_takeF   (pred_takeF),
        .stallD       (stallD),
        .flushD       (flushD),
        .branchM      (branchM),
        .jumpM        (jumpM),
        .actual_takeM (actual_takeM),
        .pcM          (pcM),
        .targetM      (targetM),
        .hitF         (hitF),
        .targetF      (targetF),
        .redirectF    (redirectF),
        .next_pcF     (next_pcF),
        .hitD         (hitD),
        .pred_targetD (pred_targetD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_m();
        branchM      = 1'b0;
        jumpM        = 1'b0;
        actual_takeM = 1'b0;
        pcM          = 32'd0;
        targetM      = 32'd0;
    endtask

    initial begin
        rst        = 1'b1;
        pcF        = 32'hFFFF_FFFC;
        pred_takeF = 1'b1;
        stallD     = 1'b0;
        flushD     = 1'b0;
        idle_m();

        // Reset: outputs quiet, PC+4 wraps.
        tick();
        tick();
        #1;
        check("rst_hitF", {31'd0, hitF}, 32'd0);
        check("rst_redirectF", {31'd0, redirectF}, 32'd0);
        check("rst_next_pc_wrap", next_pcF, 32'h0000_0000);
        check("rst_hitD", {31'd0, hitD}, 32'd0);
        check("rst_pred_targetD", pred_targetD, 32'd0);

        // First cycle after release, cold miss.
        tick();
        rst = 1'b0;
        tick();
        pcF = 32'h0040_0010;
        pred_takeF = 1'b1;
        #1;
        check("cold_hitF", {31'd0, hitF}, 32'd0);
        check("cold_next_pc", next_pcF, 32'h0040_0014);
        tick();
        check("cold_hitD", {31'd0, hitD}, 32'd0);

        // Taken branch install at index 4, tag 0x00.
        branchM = 1'b1; actual_takeM = 1'b1;
        pcM = 32'h0040_0010; targetM = 32'h0040_0100;
        tick();
        idle_m();
        pcF = 32'h0040_0010; pred_takeF = 1'b1;
        #1;
        check("br_hitF", {31'd0, hitF}, 32'd1);
        check("br_targetF", targetF, 32'h0040_0100);
        check("br_next_pc_taken", next_pcF, 32'h0040_0100);
        tick();
        check("br_hitD", {31'd0, hitD}, 32'd1);
        check("br_pred_targetD", pred_targetD, 32'h0040_0100);
        pred_takeF = 1'b0;
        #1;
        check("br_nt_hitF", {31'd0, hitF}, 32'd1);
        check("br_nt_redirectF", {31'd0, redirectF}, 32'd0);
        check("br_nt_next_pc", next_pcF, 32'h0040_0014);

        // Not-taken branch on the same PC keeps the entry.
        branchM = 1'b1; actual_takeM = 1'b0;
        pcM = 32'h0040_0010; targetM = 32'hDEAD_BEEC;
        tick();
        idle_m();
        pred_takeF = 1'b1;
        #1;
        check("nt_keep_hitF", {31'd0, hitF}, 32'd1);
        check("nt_keep_targetF", targetF, 32'h0040_0100);

        // Same-cycle read/write at empty index 8 (jump install).
        tick();
        pcF = 32'h0040_0020; pred_takeF = 1'b0;
        jumpM = 1'b1; pcM = 32'h0040_0020; targetM = 32'h0040_0400;
        #1;
        check("rw_same_cycle_hitF", {31'd0, hitF}, 32'd0);
        check("rw_same_cycle_next_pc", next_pcF, 32'h0040_0024);
        tick();
        idle_m();
        #1;
        check("rw_next_cycle_hitF", {31'd0, hitF}, 32'd1);
        check("jump_override_redirectF", {31'd0, redirectF}, 32'd1);
        check("jump_override_next_pc", next_pcF, 32'h0040_0400);

        // Conflict: index 4 with tag 0x01 replaces the earlier entry.
        branchM = 1'b1; actual_takeM = 1'b1;
        pcM = 32'h0040_0110; targetM = 32'h0040_0800;
        tick();
        idle_m();
        pcF = 32'h0040_0010; pred_takeF = 1'b1;
        #1;
        check("conflict_old_hitF", {31'd0, hitF}, 32'd0);
        check("conflict_old_next_pc", next_pcF, 32'h0040_0014);
        pcF = 32'h0040_0110;
        #1;
        check("conflict_new_hitF", {31'd0, hitF}, 32'd1);
        check("conflict_new_next_pc", next_pcF, 32'h0040_0800);

        // Jump and branch together (branch not taken) is treated as a jump.
        jumpM = 1'b1; branchM = 1'b1; actual_takeM = 1'b0;
        pcM = 32'h0040_0030; targetM = 32'h0040_1000;
        tick();
        idle_m();
        pcF = 32'h0040_0030; pred_takeF = 1'b0;
        #1;
        check("jb_both_redirectF", {31'd0, redirectF}, 32'd1);
        check("jb_both_next_pc", next_pcF, 32'h0040_1000);

        // Taken branch over the jump entry clears its jumpbit.
        branchM = 1'b1; actual_takeM = 1'b1;
        pcM = 32'h0040_0030; targetM = 32'h0040_2000;
        tick();
        idle_m();
        #1;
        check("rewrite_hitF", {31'd0, hitF}, 32'd1);
        check("rewrite_redirectF", {31'd0, redirectF}, 32'd0);
        check("rewrite_targetF", targetF, 32'h0040_2000);

        // Decode control: capture, stall hold, flush over stall.
        pcF = 32'h0040_0020; pred_takeF = 1'b0;
        tick();
        check("dec_capture_hitD", {31'd0, hitD}, 32'd1);
        check("dec_capture_targetD", pred_targetD, 32'h0040_0400);
        stallD = 1'b1; pcF = 32'h0040_0010;
        tick();
        check("dec_stall_hitD", {31'd0, hitD}, 32'd1);
        check("dec_stall_targetD", pred_targetD, 32'h0040_0400);
        flushD = 1'b1;
        tick();
        check("dec_flush_hitD", {31'd0, hitD}, 32'd0);
        check("dec_flush_targetD", pred_targetD, 32'd0);
        flushD = 1'b0; stallD = 1'b0; pcF = 32'h0040_0020;
        tick();
        check("dec_recapture_hitD", {31'd0, hitD}, 32'd1);

        // Reset mid-sequence overrides a simultaneous write and clears all entries.
        rst = 1'b1;
        jumpM = 1'b1; pcM = 32'h0040_0040; targetM = 32'h0040_4000;
        tick();
        rst = 1'b0;
        idle_m();
        #1;
        check("rst_mid_hitD", {31'd0, hitD}, 32'd0);
        check("rst_mid_hitF_0x20", {31'd0, hitF}, 32'd0);
        pcF = 32'h0040_0040;
        #1;
        check("rst_mid_write_dropped", {31'd0, hitF}, 32'd0);
        check("rst_mid_next_pc", next_pcF, 32'h0040_0044);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btb_fetch_target.md
# btb_fetch_target

Direct-mapped branch target buffer in the Fetch stage of the 5-stage MIPS pipeline. It sits beside the gshare direction predictor. Each cycle it looks up `pcF`, combines the lookup with the predictor's `pred_takeF`, and drives the speculative next PC. It is written from the Memory stage with resolved branch and jump targets. It also pipelines its hit and target into Decode so that stage can check the prediction.

## Interface
Parameters:
- `INDEX_BITS`, 6: entry count is 2^INDEX_BITS (64 entries).
- `TAG_BITS`, 8: partial tag width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pcF`  in  32  fetch PC
- `pred_takeF`  in  1  direction prediction from the global predictor, Fetch stage
- `stallD`  in  1  hold the Decode-stage registers
- `flushD`  in  1  clear the Decode-stage registers
- `branchM`  in  1  conditional branch resolved in M
- `jumpM`  in  1  unconditional direct jump (j/jal) in M
- `actual_takeM`  in  1  resolved branch direction
- `pcM`  in  32  PC of the M-stage instruction
- `targetM`  in  32  resolved target of the M-stage instruction
- `hitF`  out  1  valid entry whose tag matches `pcF`
- `targetF`  out  32  stored target (don't-care when `hitF`=0)
- `redirectF`  out  1  `hitF & (pred_takeF | jumpbitF)`
- `next_pcF`  out  32  `redirectF ? targetF : pcF+4`
- `hitD`  out  1  registered `redirectF`
- `pred_targetD`  out  32  registered `targetF`

## Operation
Address fields:
- Index = `pc[INDEX_BITS+1:2]`.
- Tag = `pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`.

Each entry holds `valid`, `tag[TAG_BITS]`, `target[32]` and `jumpbit`.

Lookup (combinational):
- `hitF` = valid[idxF] & (tag[idxF] == tagF).
- `jumpbitF` is internal. It forces the redirect regardless of `pred_takeF`.

Update at the clock edge, driven by M-stage signals:
- `jumpM`=1: write the entry at idxM with valid=1, tag=tagM, target=`targetM`, jumpbit=1.
- `branchM`=1 and `actual_takeM`=1: write the entry with valid=1, tag=tagM, target=`targetM`, jumpbit=0.
- `branchM`=1 and `actual_takeM`=0: no write. Any existing entry is retained, because the direction predictor handles not-taken.
- `jumpM` and `branchM` both high: illegal from the decoder. The block treats it as a jump (`jumpM` has priority).
- A write to an occupied index with a different tag replaces the entry. There is no associativity and no replacement policy.

Reset:
- Clears every `valid` bit and every `jumpbit`.
- Tag and target arrays are not reset. They are unreachable while `valid`=0.

Decode registers:
- `rst` or `flushD` → `hitD`=0, `pred_targetD`=0.
- Else if `~stallD` → capture `redirectF` and `targetF`.
- Else hold.

## Timing
- Lookup is zero-latency (same cycle as `pcF`). `next_pcF` feeds the PC register directly.
- An update in cycle N is visible to lookups in cycle N+1.
- Same-cycle read and write to the same index: the read returns the old contents. There is no write-through bypass.
- Output values during and after reset:
  - While `rst`=1, and on the first cycle after release, `hitF`=0 and `redirectF`=0.
  - `next_pcF` = `pcF`+4.
  - `hitD`=0 and `pred_targetD`=0.
- `rst` asserted in the middle of a sequence of updates overrides any simultaneous write. The valid bit ends at 0.
- `flushD` has priority over `stallD`.
- `pcF`+4 wraps modulo 2^32: 0xFFFFFFFC → 0x00000000.

## Test plan
1. **Cold miss.** After `rst`, drive `pcF`=0x00400010 with `pred_takeF`=1.
   → `hitF`=0, `next_pcF`=0x00400014.
   → One cycle later, `hitD`=0.
2. **Taken branch install.** Drive `branchM`=1, `actual_takeM`=1, `pcM`=0x00400010, `targetM`=0x00400100. Next cycle, drive `pcF`=0x00400010.
   - With `pred_takeF`=1 → `next_pcF`=0x00400100.
   - With `pred_takeF`=0 → `hitF`=1, `redirectF`=0, `next_pcF`=0x00400014.
3. **Jump override and conflict.**
   - Drive `jumpM`=1, `pcM`=0x00400020, `targetM`=0x00400400. Then `pcF`=0x00400020 with `pred_takeF`=0 → `next_pcF`=0x00400400.
   - Install `pcM`=0x00400110 (index 4, tag 0x01). Then `pcF`=0x00400010 → `hitF`=0, because that entry has been replaced.
4. **Same-cycle read and write.** With index 8 empty, present `pcF`=0x00400020 while writing `pcM`=0x00400020.
   → That cycle: `hitF`=0.
   → Next cycle: `hitF`=1.
5. **Not-taken retention.** With the scenario 2 entry installed, drive `branchM`=1, `actual_takeM`=0, `pcM`=0x00400010.
   → The entry persists. `hitF`=1 on the next lookup.
6. **Decode control.**
   - `stallD`=1 holds `hitD`/`pred_targetD` across a change of `pcF`.
   - `flushD`=1 together with `stallD`=1 gives 0/0.
   - `rst` in the middle of a sequence clears all entries: the next lookup of `pcF`=0x00400020 → `hitF`=0.
